// File: rtl/key_pkg.sv
// Shared types and counter widths for the push-button debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPressChk = 2'd1,
    StPressed  = 2'd2,
    StRelChk   = 2'd3
  } key_state_e;

  localparam int unsigned StabW = 4;
  localparam int unsigned HoldW = 8;
  localparam int unsigned RepW  = 8;

  localparam logic [StabW-1:0] StabOne = StabW'(1);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);
  localparam logic [RepW-1:0]  RepOne  = RepW'(1);

endpackage

// File: rtl/key_debounce_ch.sv
// One-key debounce FSM: accepts level changes after STABLE_N agreeing samples and
// generates press, release and long-press repeat pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned STABLE_N     = 2,
  parameter int unsigned HOLD_TICKS   = 12,
  parameter int unsigned REPEAT_TICKS = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic s_key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam logic [StabW-1:0] StabN     = StabW'(STABLE_N);
  localparam logic [HoldW-1:0] HoldTicks = HoldW'(HOLD_TICKS);
  localparam logic [RepW-1:0]  RepTicks  = RepW'(REPEAT_TICKS);

  key_state_e       state_q, state_d;
  logic [StabW-1:0] stab_q, stab_d, stab_inc;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign stab_inc = (stab_q == '1) ? stab_q : stab_q + StabOne;

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (s_key_i) begin
            if (STABLE_N == 1) begin
              state_d = StPressed;
              stab_d  = '0;
              level_d = 1'b1;
              press_d = 1'b1;
              hold_d  = '0;
            end else begin
              stab_d  = StabOne;
              state_d = StPressChk;
            end
          end
        end
        StPressChk: begin
          if (s_key_i) begin
            stab_d = stab_inc;
            if (stab_inc >= StabN) begin
              state_d = StPressed;
              stab_d  = '0;
              level_d = 1'b1;
              press_d = 1'b1;
              hold_d  = '0;
            end
          end else begin
            state_d = StIdle;
            stab_d  = '0;
          end
        end
        StPressed: begin
          if (!s_key_i) begin
            if (STABLE_N == 1) begin
              state_d   = StIdle;
              stab_d    = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              stab_d  = StabOne;
              state_d = StRelChk;
            end
          end else if (hold_q < HoldTicks) begin
            hold_d = hold_q + HoldOne;
            if (hold_d == HoldTicks) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end
          end else begin
            // Past the initial hold: hold_cnt only saturates, rep_cnt sets the cadence.
            hold_d = (hold_q == '1) ? hold_q : hold_q + HoldOne;
            rep_d  = rep_q + RepOne;
            if (rep_d >= RepTicks) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end
          end
        end
        StRelChk: begin
          if (!s_key_i) begin
            stab_d = stab_inc;
            if (stab_inc >= StabN) begin
              state_d   = StIdle;
              stab_d    = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      stab_q    <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: synchronises active-low buttons, derives the sample tick from
// the rising edge of clk_25hz and runs one debounce channel per key.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned STABLE_N     = 2,
  parameter int unsigned HOLD_TICKS   = 12,
  parameter int unsigned REPEAT_TICKS = 3
) (
  input  logic             clk_50Mhz,
  input  logic             rst_n,
  input  logic             clk_25hz,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_repeat
);

  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;
  logic             strobe_q, strobe_d;
  logic [KEY_W-1:0] s_key;
  logic             tick;

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    strobe_d = clk_25hz;
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      strobe_q <= strobe_d;
    end
  end

  assign s_key = ~sync2_q;
  assign tick  = clk_25hz & ~strobe_q;

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_debounce_ch #(
      .STABLE_N     (STABLE_N),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk_i     (clk_50Mhz),
      .rst_ni    (rst_n),
      .tick_i    (tick),
      .s_key_i   (s_key[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press[i]),
      .release_o (key_release[i]),
      .repeat_o  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: table-driven ticks plus long-press, bounce,
// reset and stuck-strobe sequences, with expectations queued per tick.
module tb_key_debounce;

  logic       clk_50Mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk_25hz  = 1'b0;
  logic [3:0] key_in    = 4'b0000;
  logic [3:0] key_level, key_press, key_release, key_repeat;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic [3:0] kin;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rep;
  } vec_t;

  vec_t vecs[16];

  key_debounce #(
    .KEY_W        (4),
    .STABLE_N     (2),
    .HOLD_TICKS   (12),
    .REPEAT_TICKS (3)
  ) dut (
    .clk_50Mhz   (clk_50Mhz),
    .rst_n       (rst_n),
    .clk_25hz    (clk_25hz),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  function automatic logic [15:0] outs();
    return {key_level, key_press, key_release, key_repeat};
  endfunction

  function automatic logic [15:0] ex(input logic [3:0] lvl, input logic [3:0] prs,
                                     input logic [3:0] rel, input logic [3:0] rep);
    return {lvl, prs, rel, rep};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: lvl/prs/rel/rep got %h required %h", name, act, req);
  endtask

  // One sample period (20 cycles): drive keys, strobe, compare the pulse cycle,
  // then confirm pulses cleared on the following cycle.
  task automatic step(input logic [3:0] kin, input logic [15:0] req, input string name);
    logic [15:0] got;
    @(negedge clk_50Mhz);
    key_in = kin;
    exp_q.push_back(req);
    repeat (4) @(negedge clk_50Mhz);
    clk_25hz = 1'b1;
    @(negedge clk_50Mhz);
    clk_25hz = 1'b0;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", name);
      got = '0;
    end else begin
      got = exp_q.pop_front();
      check(name, outs(), got);
    end
    @(negedge clk_50Mhz);
    check({name, "_clr"}, outs(), {got[15:12], 12'h000});
    repeat (13) @(negedge clk_50Mhz);
  endtask

  initial begin
    vecs[0]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0110, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0111, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b1111, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    vecs[15] = '{4'b1111, 4'b0000, 4'b0000, 4'b1001, 4'b0000};

    // Reset with every key held down.
    repeat (3) @(negedge clk_50Mhz);
    check("reset", outs(), 16'h0000);
    rst_n = 1'b1;
    step(4'b0000, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000), "all_t1");
    step(4'b0000, ex(4'b1111, 4'b1111, 4'b0000, 4'b0000), "all_t2");
    step(4'b1111, ex(4'b1111, 4'b0000, 4'b0000, 4'b0000), "all_r1");
    step(4'b1111, ex(4'b0000, 4'b0000, 4'b1111, 4'b0000), "all_r2");

    // Clean press/release, press bounce, simultaneous keys, release bounce.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].kin, ex(vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rep),
           $sformatf("vec%0d", i));
    end

    // Long press on key 2: press at tick 2, repeats at 14, 17, 20.
    for (int t = 1; t <= 20; t++) begin
      step(4'b1011, ex((t >= 2) ? 4'b0100 : 4'b0000, (t == 2) ? 4'b0100 : 4'b0000, 4'b0000,
                       (t == 14 || t == 17 || t == 20) ? 4'b0100 : 4'b0000),
           $sformatf("long_t%0d", t));
    end
    step(4'b1111, ex(4'b0100, 4'b0000, 4'b0000, 4'b0000), "long_r1");
    step(4'b1111, ex(4'b0000, 4'b0000, 4'b0100, 4'b0000), "long_r2");

    // Long press with a one-sample release bounce at tick 15; the two bounce ticks
    // do not advance the repeat phase, so repeats land at 14, 19, 22.
    for (int t = 1; t <= 22; t++) begin
      step((t == 15) ? 4'b1111 : 4'b1011,
           ex((t >= 2) ? 4'b0100 : 4'b0000, (t == 2) ? 4'b0100 : 4'b0000, 4'b0000,
              (t == 14 || t == 19 || t == 22) ? 4'b0100 : 4'b0000),
           $sformatf("bnc_t%0d", t));
    end
    step(4'b1111, ex(4'b0100, 4'b0000, 4'b0000, 4'b0000), "bnc_r1");
    step(4'b1111, ex(4'b0000, 4'b0000, 4'b0100, 4'b0000), "bnc_r2");

    // Key 3 pressed, then the strobe stalls while the key is released.
    step(4'b0111, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000), "k3_t1");
    step(4'b0111, ex(4'b1000, 4'b1000, 4'b0000, 4'b0000), "k3_t2");
    step(4'b0111, ex(4'b1000, 4'b0000, 4'b0000, 4'b0000), "k3_t3");
    key_in = 4'b1111;
    repeat (1000) @(negedge clk_50Mhz);
    check("stuck_tick", outs(), ex(4'b1000, 4'b0000, 4'b0000, 4'b0000));

    // Asynchronous reset mid-press, then re-debounce of the still-held key.
    key_in = 4'b0111;
    repeat (4) @(negedge clk_50Mhz);
    #3 rst_n = 1'b0;
    #1 check("mid_reset", outs(), 16'h0000);
    @(negedge clk_50Mhz);
    check("mid_reset_hold", outs(), 16'h0000);
    rst_n = 1'b1;
    step(4'b0111, ex(4'b0000, 4'b0000, 4'b0000, 4'b0000), "rep_t1");
    step(4'b0111, ex(4'b1000, 4'b1000, 4'b0000, 4'b0000), "rep_t2");
    step(4'b1111, ex(4'b1000, 4'b0000, 4'b0000, 4'b0000), "rep_r1");
    step(4'b1111, ex(4'b0000, 4'b0000, 4'b1000, 4'b0000), "rep_r2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Per-key debouncer and event generator for active-low push buttons on the board.
- Sits directly downstream of the 50 MHz clock divider. It consumes that divider's clk_25hz output as a sampling strobe.
- Produces clean pressed levels, one-cycle press and release pulses, and a long-press auto-repeat pulse.
- These outputs are consumed by the mode and control logic in the clk_50Mhz domain.

Parameters:
- KEY_W, 4, number of independent keys.
- STABLE_N, 2, consecutive identical samples required to accept a level change (range 1..15).
- HOLD_TICKS, 12, samples a key must stay pressed before the first repeat pulse (range 1..255).
- REPEAT_TICKS, 3, samples between subsequent repeat pulses while held (range 1..255).

Ports:
- clk_50Mhz  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_25hz  input  1  divider output, a register in the clk_50Mhz domain; its rising edge is the sample strobe.
- key_in  input  KEY_W  raw buttons, active-low, asynchronous to clk_50Mhz.
- key_level  output  KEY_W  debounced state, 1 = pressed.
- key_press  output  KEY_W  one-cycle pulse on accepted press.
- key_release  output  KEY_W  one-cycle pulse on accepted release.
- key_repeat  output  KEY_W  one-cycle pulse on long-press repeat.

Behaviour:
- One clock: clk_50Mhz. Reset is asynchronous and active-low on rst_n. All flops clear on rst_n low, regardless of clock.
- Reset values:
  - key_level, key_press, key_release, key_repeat = 0.
  - Both synchroniser stages = all 1s (released).
  - clk_25hz delay register = 0.
  - All per-key counters = 0. All per-key FSMs = IDLE.
- key_in passes through a 2-flop synchroniser. The stage-2 output is inverted to give s_key (1 = pressed).
- tick = clk_25hz & ~clk_25hz_d, where clk_25hz_d is clk_25hz registered once. tick is high for exactly one cycle per clk_25hz rising edge.
- No other logic advances except on tick. Between ticks, only pulse outputs change, clearing to 0.
- Per-key FSM, evaluated only when tick = 1:
  - IDLE: if s_key = 1 then stab_cnt <= 1 and go to PRESS_CHK (or, if STABLE_N = 1, go directly to PRESSED with the press action).
  - PRESS_CHK: if s_key = 1, stab_cnt++. When stab_cnt reaches STABLE_N, take the press action. If s_key = 0, return to IDLE and stab_cnt <= 0.
  - Press action: go to PRESSED, key_level <= 1, key_press pulses, hold_cnt <= 0.
  - PRESSED: if s_key = 0 then stab_cnt <= 1 and go to REL_CHK. Otherwise hold_cnt++, saturating at 255.
    - When hold_cnt reaches HOLD_TICKS, key_repeat pulses and rep_cnt <= 0.
    - After that, key_repeat pulses every REPEAT_TICKS ticks.
  - REL_CHK: if s_key = 0, stab_cnt++. When it reaches STABLE_N: go to IDLE, key_level <= 0, key_release pulses. If s_key = 1, return to PRESSED. hold_cnt and repeat phase are preserved, so a bounce does not restart the repeat timer.
- Latency: key_press and key_release assert 1 clk_50Mhz cycle after the accepting tick. All pulses are exactly one cycle wide.
- key_level changes in the same cycle as its pulse.
- key_press and key_release never assert together for the same key. key_repeat never asserts in the same cycle as key_press.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous pulses.
- If clk_25hz is stuck, no state advances and key_level holds.
- Reset asserted mid-press: all outputs return to 0 immediately, with no release pulse. After reset, a still-held key is re-debounced from IDLE and yields a fresh key_press.
- Counter widths: stab_cnt 4 bits, hold_cnt and rep_cnt 8 bits, all saturating.

Decomposition:
- Shared package key_pkg:
  - FSM state encoding: IDLE=0, PRESS_CHK=1, PRESSED=2, REL_CHK=3.
  - Counter width constants.
- Sub-module key_debounce_ch: one-key FSM plus counters, taking s_key and tick and producing level and the three pulses.
- The top module holds the synchroniser and tick edge detector, and instantiates KEY_W copies of key_debounce_ch in a generate loop.

Test Plan:
- Bench drives clk_25hz directly as a 1-cycle-high pulse every 20 clk_50Mhz cycles.
- Reset: rst_n = 0 with key_in = 4'b0000 -> all outputs 0. After release and 2 ticks, key_level = 4'b0001..4'b1111 per pressed key, and key_press pulses once for each.
- Clean press: key_in[0] low at tick k -> key_press[0] pulses once after tick k+1 (STABLE_N = 2) and key_level[0] = 1. Release it -> key_release[0] pulses once after 2 ticks and key_level[0] = 0.
- Bounce: key_in[1] low for 1 tick, high 1 tick, low 1 tick, then high -> no key_press[1], key_level[1] stays 0.
- Long press: key_in[2] held low for 20 ticks -> key_press at tick 2, key_repeat at ticks 14, 17 and 20, then no key_release until release.
- Release bounce during hold: key_in[2] high for exactly 1 tick during the hold -> no key_release, repeat cadence unchanged.
- Mid-operation reset and stuck tick: rst_n pulsed low while key_level[3] = 1 -> outputs 0 instantly and no release pulse; re-press is detected after 2 ticks. With clk_25hz held 0 for 1000 cycles, key_level is unchanged.
